// File: rtl/sccb_master_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sccb_pkg
// Brief   : Shared types and constants for the SCCB master controller.
// Revision: 1.0  initial release
// ============================================================================
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_BYTE   = 3'd2,
    ST_XBIT   = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5,
    ST_RDBYTE = 3'd6,
    ST_NABIT  = 3'd7
  } sccb_state_e;

  localparam int SLOT_WR = 29;
  localparam int SLOT_RD = 41;

  localparam logic [1:0] QTR_Q0 = 2'd0;
  localparam logic [1:0] QTR_Q1 = 2'd1;
  localparam logic [1:0] QTR_Q2 = 2'd2;
  localparam logic [1:0] QTR_Q3 = 2'd3;

  localparam logic ID_WR = 1'b0;
  localparam logic ID_RD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sccb_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : sccb_master_ctrl_if
// Brief   : Command/response handshake and SCCB pin bundle for the master.
// Revision: 1.0  initial release
// ============================================================================
interface sccb_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_id;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       scl;
  logic       sdao;
  logic       sdaoen;
  logic       sdai;

  modport master (
    input  cmd_valid, cmd_rw, cmd_id, cmd_addr, cmd_wdata, sdai,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy, scl, sdao, sdaoen
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_id, cmd_addr, cmd_wdata, sdai,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy, scl, sdao, sdaoen
  );
endinterface
`default_nettype wire

// File: rtl/sccb_master_ctrl_qtr_tick.sv
`default_nettype none
// ============================================================================
// Module  : sccb_qtr_tick
// Brief   : Quarter-bit divider; tick on the last HCLK of each quarter, q = quarter index.
// Revision: 1.0  initial release
// ============================================================================
module sccb_qtr_tick #(
  parameter int QTR_CNT = 125
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       clr,
  input  logic       en,
  output logic       tick,
  output logic [1:0] q
);
  localparam int CW = (QTR_CNT > 2) ? $clog2(QTR_CNT) : 1;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_q;

  assign tick = en && (r_cnt == CW'(QTR_CNT - 1));
  assign q    = r_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt <= '0;
      r_q   <= 2'd0;
    end else if (clr) begin
      r_cnt <= '0;
      r_q   <= 2'd0;
    end else if (tick) begin
      r_cnt <= '0;
      r_q   <= r_q + 2'd1;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/sccb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sccb_master_ctrl
// Brief   : SCCB master: 3-phase write or 2-phase write + 2-phase read per command.
// Revision: 1.0  initial release
// ============================================================================
module sccb_master_ctrl
  import sccb_pkg::*;
#(
  parameter int QTR_CNT = 125
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  sccb_master_ctrl_if.master  bus
);
  sccb_state_e r_state, w_state_nxt;
  logic [2:0]  r_bit_cnt, w_bit_nxt;
  logic [7:0]  r_tx, w_tx_nxt;
  logic [7:0]  r_rx, w_rx_nxt;
  logic [1:0]  r_byte_idx, w_byte_nxt;
  logic        r_phase, w_phase_nxt;
  logic        r_nack, w_nack_nxt;
  logic        r_rw;
  logic [6:0]  r_id;
  logic [7:0]  r_addr, r_wdata;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic        r_scl, r_sdao, r_sdaoen;
  logic        w_scl_nxt, w_sdao_nxt, w_sdaoen_nxt;
  logic        w_accept, w_busy, w_tick, w_slot_end, w_sample, w_bit_scl;
  logic [1:0]  w_q, w_q_nxt;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_accept   = bus.cmd_valid && !w_busy;
  assign w_slot_end = w_tick && (w_q == QTR_Q3);
  assign w_sample   = w_tick && (w_q == QTR_Q1);
  // Mirror of the divider's quarter update so outputs line up with the new quarter.
  assign w_q_nxt    = w_accept ? QTR_Q0 : (w_tick ? w_q + 2'd1 : w_q);

  sccb_qtr_tick #(.QTR_CNT(QTR_CNT)) u_qtr_tick (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .clr     (w_accept),
    .en      (w_busy),
    .tick    (w_tick),
    .q       (w_q)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_nxt       = r_bit_cnt;
    w_tx_nxt        = r_tx;
    w_rx_nxt        = r_rx;
    w_byte_nxt      = r_byte_idx;
    w_phase_nxt     = r_phase;
    w_nack_nxt      = r_nack;
    w_rsp_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_state_nxt = ST_START;
        w_phase_nxt = 1'b0;
        w_rx_nxt    = 8'h00;
        w_nack_nxt  = 1'b0;
      end
      ST_START: if (w_slot_end) begin
        w_state_nxt = ST_BYTE;
        w_bit_nxt   = 3'd7;
        w_byte_nxt  = 2'd0;
        w_tx_nxt    = {r_id, (r_phase ? ID_RD : ID_WR)};
      end
      ST_BYTE: if (w_slot_end) begin
        if (r_bit_cnt == 3'd0) begin
          w_state_nxt = ST_XBIT;
        end else begin
          w_bit_nxt = r_bit_cnt - 3'd1;
          w_tx_nxt  = {r_tx[6:0], 1'b0};
        end
      end
      ST_XBIT: begin
        if (w_sample && bus.sdai) w_nack_nxt = 1'b1;
        if (w_slot_end) begin
          if (r_phase) begin
            w_state_nxt = ST_RDBYTE;
            w_bit_nxt   = 3'd7;
          end else if (r_byte_idx == (r_rw ? 2'd1 : 2'd2)) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_state_nxt = ST_BYTE;
            w_bit_nxt   = 3'd7;
            w_byte_nxt  = r_byte_idx + 2'd1;
            w_tx_nxt    = (r_byte_idx == 2'd0) ? r_addr : r_wdata;
          end
        end
      end
      ST_RDBYTE: begin
        if (w_sample) w_rx_nxt = {r_rx[6:0], bus.sdai};
        if (w_slot_end) begin
          if (r_bit_cnt == 3'd0) w_state_nxt = ST_NABIT;
          else                   w_bit_nxt   = r_bit_cnt - 3'd1;
        end
      end
      ST_NABIT: if (w_slot_end) w_state_nxt = ST_STOP;
      ST_STOP: if (w_slot_end) begin
        if (r_rw && !r_phase) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b1;
        end
      end
      ST_GAP: if (w_slot_end) begin
        w_state_nxt = ST_START;
        w_phase_nxt = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Pin levels are decoded from the upcoming state/quarter so the registered pins track the FSM.
    w_scl_nxt    = 1'b1;
    w_sdao_nxt   = 1'b1;
    w_sdaoen_nxt = 1'b1;
    w_bit_scl    = (w_q_nxt == QTR_Q1) || (w_q_nxt == QTR_Q2);
    case (w_state_nxt)
      ST_START: begin
        w_scl_nxt  = (w_q_nxt != QTR_Q3);
        w_sdao_nxt = (w_q_nxt == QTR_Q0) || (w_q_nxt == QTR_Q1);
      end
      ST_BYTE: begin
        w_scl_nxt  = w_bit_scl;
        w_sdao_nxt = w_tx_nxt[7];
      end
      ST_XBIT, ST_RDBYTE: begin
        w_scl_nxt    = w_bit_scl;
        w_sdaoen_nxt = 1'b0;
      end
      ST_NABIT: w_scl_nxt = w_bit_scl;
      ST_STOP: begin
        w_scl_nxt  = (w_q_nxt != QTR_Q0);
        w_sdao_nxt = (w_q_nxt == QTR_Q2) || (w_q_nxt == QTR_Q3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_tx        <= 8'h00;
      r_rx        <= 8'h00;
      r_byte_idx  <= 2'd0;
      r_phase     <= 1'b0;
      r_nack      <= 1'b0;
      r_rw        <= 1'b0;
      r_id        <= 7'h00;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_scl       <= 1'b1;
      r_sdao      <= 1'b1;
      r_sdaoen    <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_tx        <= w_tx_nxt;
      r_rx        <= w_rx_nxt;
      r_byte_idx  <= w_byte_nxt;
      r_phase     <= w_phase_nxt;
      r_nack      <= w_nack_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_scl       <= w_scl_nxt;
      r_sdao      <= w_sdao_nxt;
      r_sdaoen    <= w_sdaoen_nxt;
      if (w_accept) begin
        r_rw    <= bus.cmd_rw;
        r_id    <= bus.cmd_id;
        r_addr  <= bus.cmd_addr;
        r_wdata <= bus.cmd_wdata;
      end
    end
  end

  assign bus.cmd_ready = !w_busy;
  assign bus.busy      = w_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rx;
  assign bus.rsp_nack  = r_nack;
  assign bus.scl       = r_scl;
  assign bus.sdao      = r_sdao;
  assign bus.sdaoen    = r_sdaoen;
endmodule
`default_nettype wire

// File: tb/tb_sccb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sccb_master_ctrl
// Brief   : Directed bench for sccb_master_ctrl with a behavioural SCCB slave and bus monitor.
// Revision: 1.0  initial release
// ============================================================================
module tb_sccb_master_ctrl;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  sccb_master_ctrl_if bus();

  sccb_master_ctrl #(.QTR_CNT(4)) u_dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  // Slave model: acks with 0 (or floats high when absent), returns slave_rd on read-data bits.
  logic       slave_absent = 1'b0;
  logic [7:0] slave_rd = 8'h00;
  logic       slave_drv;
  logic       mon_clr = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         start_cnt = 0, stop_cnt = 0, rel_cnt = 0, oen_low = 0, nbits = 0;
  logic       bits [0:127];

  always_comb begin
    slave_drv = 1'b0;
    if (slave_absent)                      slave_drv = 1'b1;
    else if (rel_cnt >= 3 && rel_cnt <= 10) slave_drv = slave_rd[3'(10 - rel_cnt)];
  end
  assign bus.sdai = bus.sdaoen ? bus.sdao : slave_drv;

  always @(negedge HCLK) begin
    if (mon_clr) begin
      start_cnt <= 0; stop_cnt <= 0; rel_cnt <= 0; oen_low <= 0; nbits <= 0;
    end else begin
      if (prev_scl && bus.scl && (prev_sda !== bus.sdai)) begin
        if (bus.sdai) stop_cnt  <= stop_cnt + 1;
        else          start_cnt <= start_cnt + 1;
      end
      if (!prev_scl && bus.scl) begin
        if (nbits < 128) bits[nbits] <= bus.sdai;
        nbits <= nbits + 1;
      end
      if (prev_scl && !bus.scl && !bus.sdaoen) rel_cnt <= rel_cnt + 1;
      if (!bus.sdaoen) oen_low <= oen_low + 1;
    end
    prev_scl <= bus.scl;
    prev_sda <= bus.sdai;
  end

  function automatic logic [7:0] get_byte(input int s);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], bits[s + i]};
    return b;
  endfunction

  task automatic mon_reset();
    @(negedge HCLK); mon_clr = 1'b1;
    @(negedge HCLK); mon_clr = 1'b0;
  endtask

  task automatic issue(input logic rw, input logic [6:0] id, input logic [7:0] addr,
                       input logic [7:0] wdata);
    @(negedge HCLK);
    bus.cmd_rw = rw; bus.cmd_id = id; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1;
    @(posedge HCLK); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge HCLK); #1;
      if (bus.rsp_valid) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_id = 7'h00;
    bus.cmd_addr = 8'h00; bus.cmd_wdata = 8'h00;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    n_vec++;
    if ({bus.scl, bus.sdao, bus.sdaoen, bus.busy, bus.cmd_ready, bus.rsp_valid, bus.rsp_nack} !== 7'b1110100) begin
      n_err++; $display("FAIL reset_outputs got %b want 1110100",
        {bus.scl, bus.sdao, bus.sdaoen, bus.busy, bus.cmd_ready, bus.rsp_valid, bus.rsp_nack});
    end
    n_vec++;
    if (bus.rsp_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got %h want 00", bus.rsp_rdata); end
    @(negedge HCLK); HRESETn = 1'b1;
  endtask

  task automatic test_write();
    int lat;
    slave_absent = 1'b0;
    mon_reset();
    issue(1'b0, 7'h21, 8'h12, 8'h80);
    wait_rsp(lat);
    n_vec++; if (lat !== 464) begin n_err++; $display("FAIL wr_latency got %0d want 464", lat); end
    n_vec++; if (bus.rsp_nack !== 1'b0) begin n_err++; $display("FAIL wr_nack got %b want 0", bus.rsp_nack); end
    n_vec++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL wr_idle got ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy); end
    n_vec++; if (nbits !== 28) begin n_err++; $display("FAIL wr_nbits got %0d want 28", nbits); end
    n_vec++; if ({get_byte(0), get_byte(9), get_byte(18)} !== 24'h421280) begin
      n_err++; $display("FAIL wr_bytes got %h want 421280", {get_byte(0), get_byte(9), get_byte(18)}); end
    n_vec++; if ({bits[8], bits[17], bits[26]} !== 3'b000) begin
      n_err++; $display("FAIL wr_acks got %b want 000", {bits[8], bits[17], bits[26]}); end
    n_vec++; if (start_cnt !== 1 || stop_cnt !== 1) begin
      n_err++; $display("FAIL wr_start_stop got %0d/%0d want 1/1", start_cnt, stop_cnt); end
    n_vec++; if (oen_low !== 48) begin n_err++; $display("FAIL wr_release got %0d want 48", oen_low); end
  endtask

  task automatic test_read();
    int lat;
    slave_absent = 1'b0;
    slave_rd = 8'h76;
    mon_reset();
    issue(1'b1, 7'h21, 8'h0A, 8'hFF);
    wait_rsp(lat);
    n_vec++; if (lat !== 656) begin n_err++; $display("FAIL rd_latency got %0d want 656", lat); end
    n_vec++; if (bus.rsp_rdata !== 8'h76) begin n_err++; $display("FAIL rd_data got %h want 76", bus.rsp_rdata); end
    n_vec++; if (bus.rsp_nack !== 1'b0) begin n_err++; $display("FAIL rd_nack got %b want 0", bus.rsp_nack); end
    n_vec++; if (nbits !== 38) begin n_err++; $display("FAIL rd_nbits got %0d want 38", nbits); end
    n_vec++; if ({get_byte(0), get_byte(9), get_byte(19), get_byte(28)} !== 32'h420A4376) begin
      n_err++; $display("FAIL rd_bytes got %h want 420a4376",
        {get_byte(0), get_byte(9), get_byte(19), get_byte(28)}); end
    n_vec++; if ({bits[18], bits[36]} !== 2'b01) begin
      n_err++; $display("FAIL rd_stop_na got %b want 01", {bits[18], bits[36]}); end
    n_vec++; if (start_cnt !== 2 || stop_cnt !== 2) begin
      n_err++; $display("FAIL rd_start_stop got %0d/%0d want 2/2", start_cnt, stop_cnt); end
    n_vec++; if (oen_low !== 176) begin n_err++; $display("FAIL rd_release got %0d want 176", oen_low); end
  endtask

  task automatic test_no_slave();
    int lat;
    slave_absent = 1'b1;
    mon_reset();
    issue(1'b0, 7'h21, 8'h33, 8'h55);
    n_vec++; if (bus.rsp_rdata !== 8'h00) begin
      n_err++; $display("FAIL ns_rdata_clear got %h want 00", bus.rsp_rdata); end
    wait_rsp(lat);
    n_vec++; if (lat !== 464) begin n_err++; $display("FAIL ns_latency got %0d want 464", lat); end
    n_vec++; if (bus.rsp_nack !== 1'b1) begin n_err++; $display("FAIL ns_nack got %b want 1", bus.rsp_nack); end
    n_vec++; if (get_byte(18) !== 8'h55) begin n_err++; $display("FAIL ns_wdata got %h want 55", get_byte(18)); end
    n_vec++; if (start_cnt !== 1 || stop_cnt !== 1) begin
      n_err++; $display("FAIL ns_start_stop got %0d/%0d want 1/1", start_cnt, stop_cnt); end
    slave_absent = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    mon_reset();
    @(negedge HCLK);
    bus.cmd_rw = 1'b0; bus.cmd_id = 7'h21; bus.cmd_addr = 8'h11; bus.cmd_wdata = 8'h5A;
    bus.cmd_valid = 1'b1;
    @(posedge HCLK); #1;
    n_vec++; if ({bus.busy, bus.cmd_ready, bus.rsp_nack} !== 3'b100) begin
      n_err++; $display("FAIL b2b_accept got busy/ready/nack=%b want 100", {bus.busy, bus.cmd_ready, bus.rsp_nack}); end
    wait_rsp(lat);
    n_vec++; if (lat !== 464 || bus.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_first got lat=%0d ready=%b want 464 1", lat, bus.cmd_ready); end
    bus.cmd_addr = 8'h34; bus.cmd_wdata = 8'hC3;
    @(posedge HCLK); #1;
    bus.cmd_valid = 1'b0;
    n_vec++; if ({bus.busy, bus.rsp_valid, bus.scl, bus.sdao} !== 4'b1011) begin
      n_err++; $display("FAIL b2b_restart got %b want 1011", {bus.busy, bus.rsp_valid, bus.scl, bus.sdao}); end
    wait_rsp(lat);
    n_vec++; if (lat !== 464) begin n_err++; $display("FAIL b2b_second got %0d want 464", lat); end
    n_vec++; if (nbits !== 56) begin n_err++; $display("FAIL b2b_nbits got %0d want 56", nbits); end
    n_vec++; if ({get_byte(18), get_byte(28), get_byte(37), get_byte(46)} !== 32'h5A4234C3) begin
      n_err++; $display("FAIL b2b_bytes got %h want 5a4234c3",
        {get_byte(18), get_byte(28), get_byte(37), get_byte(46)}); end
    n_vec++; if (start_cnt !== 2 || stop_cnt !== 2) begin
      n_err++; $display("FAIL b2b_start_stop got %0d/%0d want 2/2", start_cnt, stop_cnt); end
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(1'b0, 7'h21, 8'h0F, 8'h0F);
    repeat (183) begin @(posedge HCLK); #1; end
    n_vec++; if ({bus.scl, bus.sdao, bus.busy} !== 3'b101) begin
      n_err++; $display("FAIL rm_pre got scl/sdao/busy=%b want 101", {bus.scl, bus.sdao, bus.busy}); end
    @(negedge HCLK); HRESETn = 1'b0; #1;
    n_vec++; if ({bus.scl, bus.sdao, bus.sdaoen, bus.busy, bus.cmd_ready} !== 5'b11101) begin
      n_err++; $display("FAIL rm_abort got %b want 11101",
        {bus.scl, bus.sdao, bus.sdaoen, bus.busy, bus.cmd_ready}); end
    @(negedge HCLK); HRESETn = 1'b1;
    mon_reset();
    issue(1'b0, 7'h21, 8'h12, 8'hA5);
    wait_rsp(lat);
    n_vec++; if (lat !== 464) begin n_err++; $display("FAIL rm_latency got %0d want 464", lat); end
    n_vec++; if ({get_byte(0), get_byte(9), get_byte(18)} !== 24'h4212A5) begin
      n_err++; $display("FAIL rm_bytes got %h want 4212a5", {get_byte(0), get_byte(9), get_byte(18)}); end
    n_vec++; if (bus.rsp_nack !== 1'b0 || start_cnt !== 1 || stop_cnt !== 1) begin
      n_err++; $display("FAIL rm_status got nack=%b start=%0d stop=%0d want 0 1 1",
        bus.rsp_nack, start_cnt, stop_cnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_no_slave();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
